joypad_port: RTL and testbench

- Responder end of the controller port driven by the CPU core's GPIO interface.
- Models two NES-style 4021 parallel-in/serial-out pads:
  - latches button state while the strobe bit (written to $4016) is high;
  - serialises one bit per read of $4016/$4017.
- Sits between the board button pins (asynchronous, bouncy) and the core's GPIO read/write lines.
- Its serial outputs feed the core's 2-bit serial data input directly.

---
 rtl/joypad_port.sv | 110 +++++++++++
 tb/tb_joypad_port.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/joypad_port.sv
`default_nettype none
// ============================================================================
// Module   : joypad_port
// Brief    : Two NES-style 4021 pads: sync, debounce, strobe-load, serial read.
// Revision : 1.0
// ============================================================================
module joypad_port #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter bit PRESSED_HIGH    = 1'b1
) (
    input  logic       I_clock,
    input  logic       I_reset,
    input  logic [7:0] I_GPIO_data,
    input  logic [1:0] I_GPIO_rden,
    output logic [1:0] O_GPIO_data,
    input  logic [7:0] I_pad0_buttons,
    input  logic [7:0] I_pad1_buttons
);

    localparam int             CNT_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [15:0]    POLARITY = {16{~PRESSED_HIGH}};

    logic [15:0]      pins;
    logic [15:0]      sync_meta;
    logic [15:0]      sync_stable;
    logic [15:0]      active;
    logic [CNT_W-1:0] tick_count;
    logic             tick;
    logic [15:0]      prev_sample;
    logic [15:0]      debounced;
    logic [15:0]      accept;
    logic [1:0]       rden_q;
    logic [1:0]       rden_fall;
    logic             strobe;
    logic [7:0]       shift_reg [2];

    // Only bit 0 of the written value carries meaning.
    logic unused_gpio_bits;
    assign unused_gpio_bits = &{1'b0, I_GPIO_data[7:1]};

    assign pins   = {I_pad1_buttons, I_pad0_buttons};
    assign strobe = I_GPIO_data[0];

    always_ff @(posedge I_clock or posedge I_reset) begin
        if (I_reset) begin
            sync_meta   <= '0;
            sync_stable <= '0;
        end else begin
            sync_meta   <= pins;
            sync_stable <= sync_meta;
        end
    end

    assign active = sync_stable ^ POLARITY;

    always_ff @(posedge I_clock or posedge I_reset) begin
        if (I_reset) begin
            tick_count <= '0;
        end else if (tick) begin
            tick_count <= '0;
        end else begin
            tick_count <= tick_count + 1'b1;
        end
    end

    assign tick = (tick_count == CNT_MAX);

    // A pin is accepted only when two consecutive tick samples agree.
    assign accept = ~(active ^ prev_sample);

    always_ff @(posedge I_clock or posedge I_reset) begin
        if (I_reset) begin
            prev_sample <= '0;
            debounced   <= '0;
        end else if (tick) begin
            prev_sample <= active;
            debounced   <= (active & accept) | (debounced & ~accept);
        end
    end

    always_ff @(posedge I_clock or posedge I_reset) begin
        if (I_reset) begin
            rden_q <= '0;
        end else begin
            rden_q <= I_GPIO_rden;
        end
    end

    // Shift at the end of an access so the core sees a stable bit throughout.
    assign rden_fall = rden_q & ~I_GPIO_rden;

    generate
        for (genvar p = 0; p < 2; p++) begin : g_pad
            always_ff @(posedge I_clock or posedge I_reset) begin
                if (I_reset) begin
                    shift_reg[p] <= 8'h00;
                end else if (strobe) begin
                    shift_reg[p] <= debounced[8*p +: 8];
                end else if (rden_fall[p]) begin
                    shift_reg[p] <= {1'b1, shift_reg[p][7:1]};
                end
            end

            assign O_GPIO_data[p] = shift_reg[p][0];
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_joypad_port.sv
`default_nettype none
// Directed bench for joypad_port with a queue scoreboard of expected read bits.
module tb_joypad_port;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] gpio_wdata;
    logic [1:0] gpio_rden;
    logic [1:0] gpio_out;
    logic [7:0] pad0;
    logic [7:0] pad1;

    typedef struct {
        string tag;
        int    pad;
        logic  exp;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    joypad_port #(
        .DEBOUNCE_CYCLES(4),
        .PRESSED_HIGH   (1'b1)
    ) dut (
        .I_clock       (clk),
        .I_reset       (rst),
        .I_GPIO_data   (gpio_wdata),
        .I_GPIO_rden   (gpio_rden),
        .O_GPIO_data   (gpio_out),
        .I_pad0_buttons(pad0),
        .I_pad1_buttons(pad1)
    );

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe_pulse();
        gpio_wdata = 8'h01;
        step();
        step();
        gpio_wdata = 8'h00;
        step();
    endtask

    task automatic do_read(input int pad, input logic exp, input string tag);
        exp_t e;
        sb.push_back('{tag, pad, exp});
        gpio_rden[pad] = 1'b1;
        step();
        e = sb.pop_front();
        check(e.tag, {7'd0, gpio_out[e.pad]}, {7'd0, e.exp});
        step();
        gpio_rden[pad] = 1'b0;
        step();
        step();
    endtask

    task automatic read_stream(input int pad, input logic [7:0] value, input string tag);
        for (int i = 0; i < 8; i++) begin
            do_read(pad, value[i], $sformatf("%s_b%0d", tag, i));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic found;
        logic seen;
        logic [7:0] v90;
        logic [7:0] v02;

        rst        = 1'b1;
        gpio_wdata = 8'h00;
        gpio_rden  = 2'b00;
        pad0       = 8'h00;
        pad1       = 8'h00;

        // Reset state and idle reads
        #12;
        check("reset_out", {6'd0, gpio_out}, 8'h00);
        @(posedge clk);
        #1;
        rst = 1'b0;
        step();
        check("post_reset_out", {6'd0, gpio_out}, 8'h00);
        strobe_pulse();
        read_stream(0, 8'h00, "idle");
        do_read(0, 1'b1, "idle_over8");
        do_read(0, 1'b1, "idle_over9");

        // Pad 0 A+Start
        pad0 = 8'h09;
        repeat (20) step();
        strobe_pulse();
        read_stream(0, 8'h09, "astart");
        do_read(0, 1'b1, "astart_over");

        // Interleaved pads
        pad0 = 8'h02;
        pad1 = 8'h90;
        repeat (20) step();
        strobe_pulse();
        v90 = 8'h90;
        v02 = 8'h02;
        for (int i = 0; i < 8; i++) begin
            do_read(1, v90[i], $sformatf("p1_b%0d", i));
            do_read(0, v02[i], $sformatf("p0_b%0d", i));
        end
        do_read(1, 1'b1, "p1_over");
        pad0 = 8'h00;
        pad1 = 8'h00;

        // Strobe held high: reads never shift
        pad0 = 8'h01;
        repeat (20) step();
        gpio_wdata = 8'h01;
        step();
        step();
        check("strobe_hi_A", {7'd0, gpio_out[0]}, 8'h01);
        for (int i = 0; i < 3; i++) begin
            do_read(0, 1'b1, $sformatf("strobe_hi_rd%0d", i));
        end
        pad0  = 8'h00;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            step();
            if (dut.debounced[0] === 1'b0) found = 1'b1;
        end
        check("deb_release_seen", {7'd0, found}, 8'h01);
        check("release_same_clk", {7'd0, gpio_out[0]}, 8'h01);
        step();
        check("release_next_clk", {7'd0, gpio_out[0]}, 8'h00);
        gpio_wdata = 8'h00;
        step();

        // Bounce aligned so every tick sample lands on a low phase
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            if (dut.tick === 1'b1) found = 1'b1;
            else step();
        end
        check("tick_seen", {7'd0, found}, 8'h01);
        step();
        seen = 1'b0;
        for (int s = 0; s < 10; s++) begin
            pad0[0] = (s % 2 == 0);
            step();
            if (dut.debounced[0] === 1'b1) seen = 1'b1;
        end
        pad0 = 8'h00;
        for (int s = 0; s < 16; s++) begin
            step();
            if (dut.debounced[0] === 1'b1) seen = 1'b1;
        end
        check("bounce_never_accepted", {7'd0, seen}, 8'h00);
        strobe_pulse();
        do_read(0, 1'b0, "bounce_A");
        do_read(0, 1'b0, "bounce_B");

        // Reset mid-sequence
        pad0 = 8'hFF;
        repeat (20) step();
        strobe_pulse();
        for (int i = 0; i < 3; i++) begin
            do_read(0, 1'b1, $sformatf("pre_rst_rd%0d", i));
        end
        check("pre_reset_bit", {7'd0, gpio_out[0]}, 8'h01);
        #2;
        rst = 1'b1;
        #1;
        check("async_reset", {6'd0, gpio_out}, 8'h00);
        @(posedge clk);
        #1;
        rst = 1'b0;
        step();
        read_stream(0, 8'h00, "after_rst");
        do_read(0, 1'b1, "after_rst_over");

        check("scoreboard_empty", 8'(sb.size()), 8'h00);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
